// File: rtl/centroid_marker_pkg.sv
// Shared video timing constants and marker FSM encoding.
package centroid_marker_pkg;

  localparam int unsigned H_ACTIVE = 1024;
  localparam int unsigned V_ACTIVE = 768;
  localparam int unsigned HCOUNT_W = 11;
  localparam int unsigned VCOUNT_W = 10;

  typedef enum logic {
    StIdle  = 1'b0,
    StTrack = 1'b1
  } state_e;

  // Unsigned distance; never wraps, so crosshair arms clip at frame edges.
  function automatic logic [HCOUNT_W-1:0] abs_diff(input logic [HCOUNT_W-1:0] a,
                                                   input logic [HCOUNT_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/centroid_marker_ema.sv
// Per-axis 3/4-1/4 smoother: either loads the new sample or blends it in.
module ema_filter #(
  parameter int unsigned W = 11
) (
  input  logic [W-1:0] cur_i,
  input  logic [W-1:0] pend_i,
  input  logic         load_i,
  output logic [W-1:0] next_o
);

  logic [W+1:0] sum;

  // 3*cur + pend needs two extra bits; shift truncates toward zero.
  always_comb begin
    sum    = ({2'b00, cur_i} << 1) + {2'b00, cur_i} + {2'b00, pend_i};
    next_o = load_i ? pend_i : W'(sum >> 2);
  end

endmodule

// File: rtl/centroid_marker.sv
// Overlays a smoothed crosshair on the video at the latest centroid.
module centroid_marker
  import centroid_marker_pkg::*;
#(
  parameter int unsigned MARK_HALF      = 8,
  parameter logic [7:0]  MARK_COLOR     = 8'h80,
  parameter int unsigned TIMEOUT_FRAMES = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [HCOUNT_W-1:0] hcount,
  input  logic [VCOUNT_W-1:0] vcount,
  input  logic [7:0]          pixel_in,
  input  logic [HCOUNT_W-1:0] cx,
  input  logic [VCOUNT_W-1:0] cy,
  input  logic                c_valid,
  output logic [7:0]          pixel_out,
  output logic [HCOUNT_W-1:0] mx,
  output logic [VCOUNT_W-1:0] my,
  output logic                tracking
);

  localparam int unsigned MissW = $clog2(TIMEOUT_FRAMES + 1);

  state_e              state_q, state_d;
  logic [HCOUNT_W-1:0] mx_q, mx_d, pend_x_q, pend_x_d, ema_x;
  logic [VCOUNT_W-1:0] my_q, my_d, pend_y_q, pend_y_d, ema_y;
  logic                new_q, new_d;
  logic [MissW-1:0]    miss_q, miss_d, miss_inc;
  logic [7:0]          pix_q, pix_d;

  logic                frame_start;
  logic                visible;
  logic                hit;
  logic [HCOUNT_W-1:0] dist_h;
  logic [HCOUNT_W-1:0] dist_v;

  ema_filter #(.W(HCOUNT_W)) u_ema_x (
    .cur_i  (mx_q),
    .pend_i (pend_x_q),
    .load_i (state_q == StIdle),
    .next_o (ema_x)
  );

  ema_filter #(.W(VCOUNT_W)) u_ema_y (
    .cur_i  (my_q),
    .pend_i (pend_y_q),
    .load_i (state_q == StIdle),
    .next_o (ema_y)
  );

  // Position/FSM next state; moves only at frame start, c_valid latched last.
  always_comb begin
    state_d  = state_q;
    mx_d     = mx_q;
    my_d     = my_q;
    pend_x_d = pend_x_q;
    pend_y_d = pend_y_q;
    new_d    = new_q;
    miss_d   = miss_q;
    miss_inc = miss_q + MissW'(1);

    if (frame_start) begin
      if (new_q) begin
        // In IDLE the filters pass pending straight through.
        mx_d    = ema_x;
        my_d    = ema_y;
        state_d = StTrack;
        miss_d  = '0;
        new_d   = 1'b0;
      end else if (state_q == StTrack) begin
        miss_d = miss_inc;
        if (miss_inc == MissW'(TIMEOUT_FRAMES)) begin
          state_d = StIdle;
          miss_d  = '0;
        end
      end
    end

    // A coincident c_valid does not affect this frame's update but stays pending.
    if (c_valid) begin
      pend_x_d = cx;
      pend_y_d = cy;
      new_d    = 1'b1;
    end
  end

  // Marker hit test and registered output pixel.
  always_comb begin
    frame_start = (hcount == '0) && (vcount == '0);
    visible     = (hcount < HCOUNT_W'(H_ACTIVE)) && (vcount < VCOUNT_W'(V_ACTIVE));
    dist_h      = abs_diff(hcount, mx_q);
    dist_v      = abs_diff({1'b0, vcount}, {1'b0, my_q});
    hit         = (state_q == StTrack) &&
                  (((hcount == mx_q) && (dist_v <= HCOUNT_W'(MARK_HALF))) ||
                   ((vcount == my_q) && (dist_h <= HCOUNT_W'(MARK_HALF))));
    pix_d       = !visible ? 8'h00 : (hit ? MARK_COLOR : pixel_in);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      mx_q     <= '0;
      my_q     <= '0;
      pend_x_q <= '0;
      pend_y_q <= '0;
      new_q    <= 1'b0;
      miss_q   <= '0;
      pix_q    <= 8'h00;
    end else begin
      state_q  <= state_d;
      mx_q     <= mx_d;
      my_q     <= my_d;
      pend_x_q <= pend_x_d;
      pend_y_q <= pend_y_d;
      new_q    <= new_d;
      miss_q   <= miss_d;
      pix_q    <= pix_d;
    end
  end

  assign pixel_out = pix_q;
  assign mx        = mx_q;
  assign my        = my_q;
  assign tracking  = (state_q == StTrack);

endmodule

// File: tb/tb_centroid_marker.sv
// Directed bench for centroid_marker with a pixel scoreboard.
module tb_centroid_marker;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [7:0]  pixel_in;
  logic [10:0] cx;
  logic [9:0]  cy;
  logic        c_valid;
  logic [7:0]  pixel_out;
  logic [10:0] mx;
  logic [9:0]  my;
  logic        tracking;

  int passed = 0;
  int total  = 0;
  logic [7:0] sb_q[$];
  int em_x, em_y;

  always #5 clk = ~clk;

  centroid_marker dut (
    .clk       (clk),
    .reset     (reset),
    .hcount    (hcount),
    .vcount    (vcount),
    .pixel_in  (pixel_in),
    .cx        (cx),
    .cy        (cy),
    .c_valid   (c_valid),
    .pixel_out (pixel_out),
    .mx        (mx),
    .my        (my),
    .tracking  (tracking)
  );

  function automatic int ema(input int cur, input int p);
    return (3 * cur + p) / 4;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Park off-screen and away from frame start.
  task automatic park();
    hcount = 11'd1100;
    vcount = 10'd0;
  endtask

  task automatic fs();
    hcount = 11'd0;
    vcount = 10'd0;
    tick();
    park();
  endtask

  task automatic cv(input int x, input int y);
    cx      = 11'(x);
    cy      = 10'(y);
    c_valid = 1'b1;
    tick();
    c_valid = 1'b0;
  endtask

  task automatic pix(input int h, input int v, input logic [7:0] pin, input logic [7:0] exp);
    logic [7:0] e;
    hcount   = 11'(h);
    vcount   = 10'(v);
    pixel_in = pin;
    sb_q.push_back(exp);
    tick();
    e = sb_q.pop_front();
    check($sformatf("pixel(%0d,%0d)", h, v), {24'd0, pixel_out}, {24'd0, e});
    park();
  endtask

  task automatic check_pos(input string tag, input int x, input int y, input logic trk);
    check({tag, ".mx"}, {21'd0, mx}, 32'(x));
    check({tag, ".my"}, {22'd0, my}, 32'(y));
    check({tag, ".tracking"}, {31'd0, tracking}, {31'd0, trk});
  endtask

  initial begin
    reset    = 1'b1;
    c_valid  = 1'b0;
    cx       = '0;
    cy       = '0;
    hcount   = 11'd10;
    vcount   = 10'd10;
    pixel_in = 8'hff;
    repeat (3) tick();
    check("reset.pixel_out", {24'd0, pixel_out}, 32'd0);
    check_pos("reset", 0, 0, 1'b0);
    reset = 1'b0;
    park();
    tick();

    // First update loads directly.
    cv(500, 300);
    check_pos("no_move_before_fs", 0, 0, 1'b0);
    fs();
    em_x = 500;
    em_y = 300;
    check_pos("load", em_x, em_y, 1'b1);
    pix(500, 292, 8'h11, 8'h80);
    pix(508, 300, 8'h22, 8'h80);
    pix(500, 291, 8'h33, 8'h33);
    pix(509, 300, 8'h44, 8'h44);
    pix(492, 300, 8'h45, 8'h80);
    pix(1024, 5, 8'h55, 8'h00);
    pix(5, 768, 8'h66, 8'h00);

    // Smoothing step.
    cv(600, 100);
    fs();
    em_x = ema(em_x, 600);
    em_y = ema(em_y, 100);
    check_pos("ema", em_x, em_y, 1'b1);

    // 14 misses keep tracking; a new update clears the miss count.
    repeat (14) fs();
    check_pos("miss14", em_x, em_y, 1'b1);
    cv(em_x, em_y);
    fs();
    check_pos("miss_reset", em_x, em_y, 1'b1);
    repeat (14) fs();
    check("miss14_again.tracking", {31'd0, tracking}, 32'd1);
    fs();
    check_pos("timeout", em_x, em_y, 1'b0);
    pix(em_x, em_y, 8'h77, 8'h77);

    // Corner clipping with marker at (3,2).
    cv(3, 2);
    fs();
    check_pos("corner", 3, 2, 1'b1);
    for (int c = 0; c <= 12; c++) begin
      pix(c, 2, 8'(8'h10 + c), (c <= 11) ? 8'h80 : 8'(8'h10 + c));
    end
    for (int r = 0; r <= 11; r++) begin
      pix(3, r, 8'(8'h30 + r), (r <= 10) ? 8'h80 : 8'(8'h30 + r));
    end
    pix(4, 3, 8'h99, 8'h99);
    pix(2047, 2, 8'h5a, 8'h00);
    pix(3, 1023, 8'h5b, 8'h00);

    // c_valid coincident with frame start takes effect next frame.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cv(200, 200);
    fs();
    check_pos("coinc_load", 200, 200, 1'b1);
    hcount  = 11'd0;
    vcount  = 10'd0;
    cx      = 11'd100;
    cy      = 10'd100;
    c_valid = 1'b1;
    tick();
    c_valid = 1'b0;
    park();
    check_pos("coinc_hold", 200, 200, 1'b1);
    fs();
    check_pos("coinc_next", ema(200, 100), ema(200, 100), 1'b1);

    // Latest of two c_valids wins.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cv(10, 10);
    cv(40, 41);
    fs();
    check_pos("overwrite", 40, 41, 1'b1);

    // Reset mid-frame discards pending centroid.
    cv(700, 400);
    hcount   = 11'd50;
    vcount   = 10'd60;
    pixel_in = 8'hab;
    reset    = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset.pixel_out", {24'd0, pixel_out}, 32'd0);
    check_pos("midreset", 0, 0, 1'b0);
    park();
    fs();
    check_pos("midreset_fs", 0, 0, 1'b0);
    pix(0, 5, 8'h42, 8'h42);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
